// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings, default widths
// and the statistics counter width.
package dmem_arb_pkg;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_C    = 2'b01;
  localparam logic [1:0] OWN_N    = 2'b10;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int STATS_W    = 32;

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating event counter used for per-port wait-cycle statistics.
// Clear takes priority over a same-cycle increment.
module dmem_arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = STATS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the data memory between the core (C)
// and the NIC (N). Optional wait statistics when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              n_req,
  input  logic              n_wr,
  input  logic [ADDR_W-1:0] n_addr,
  input  logic [DATA_W-1:0] n_wdata,
  output logic              n_gnt,
  output logic              n_rvalid,
  output logic [DATA_W-1:0] n_rdata,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] c_wait_cnt,
  output logic [STATS_W-1:0] n_wait_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       win;
  logic             burst_left;
  logic             c_rvalid_q, n_rvalid_q;

  // Winner selection: the owner keeps the memory until its burst budget is spent
  // and the peer is waiting; ties otherwise alternate away from the last winner.
  always_comb begin
    win        = OWN_IDLE;
    burst_left = (cnt_q < BURST_MAX);
    if (!reset) begin
      win = OWN_IDLE;
    end else if ((owner_q == OWN_C) && c_req && (burst_left || !n_req)) begin
      win = OWN_C;
    end else if ((owner_q == OWN_N) && n_req && (burst_left || !c_req)) begin
      win = OWN_N;
    end else if (c_req && n_req) begin
      win = (last_q == OWN_C) ? OWN_N : OWN_C;
    end else if (c_req) begin
      win = OWN_C;
    end else if (n_req) begin
      win = OWN_N;
    end
  end

  always_comb begin
    c_gnt     = 1'b0;
    n_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (win)
      OWN_C: begin
        c_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_wr_en = c_wr;
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
      end
      OWN_N: begin
        n_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_wr_en = n_wr;
        mem_addr  = n_addr;
        mem_wdata = n_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (win != OWN_IDLE) begin
      owner_d = win;
      last_d  = win;
      if (win == owner_q) begin
        cnt_d = burst_left ? (cnt_q + CNT_W'(1)) : cnt_q;
      end else begin
        cnt_d = CNT_W'(1);
      end
    end else begin
      owner_d = OWN_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q    <= OWN_IDLE;
      last_q     <= OWN_C;
      cnt_q      <= '0;
      c_rvalid_q <= 1'b0;
      n_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      c_rvalid_q <= c_gnt & ~c_wr;
      n_rvalid_q <= n_gnt & ~n_wr;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign n_rvalid = n_rvalid_q;
  assign c_rdata  = mem_rdata;
  assign n_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_counter #(.WIDTH(STATS_W)) u_c_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (c_req & ~c_gnt),
    .clr   (stats_clr),
    .cnt   (c_wait_cnt)
  );

  dmem_arb_sat_counter #(.WIDTH(STATS_W)) u_n_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (n_req & ~n_gnt),
    .clr   (stats_clr),
    .cnt   (n_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a behavioural model
// of the arbitration rules and a small memory; also covers DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_wr, n_req, n_wr;
  logic [AW-1:0] c_addr, n_addr;
  logic [DW-1:0] c_wdata, n_wdata;
  logic          c_gnt, n_gnt, c_rvalid, n_rvalid;
  logic [DW-1:0] c_rdata, n_rdata;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic          stats_clr;
  logic [31:0]   c_wait_cnt, n_wait_cnt;
  logic [31:0]   m_cwait, m_nwait;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_wr      (c_wr),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .n_req     (n_req),
    .n_wr      (n_wr),
    .n_addr    (n_addr),
    .n_wdata   (n_wdata),
    .n_gnt     (n_gnt),
    .n_rvalid  (n_rvalid),
    .n_rdata   (n_rdata),
    .mem_en    (mem_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr (stats_clr),
    .c_wait_cnt(c_wait_cnt),
    .n_wait_cnt(n_wait_cnt),
`endif
    .mem_rdata (mem_rdata)
  );

  function automatic logic [63:0] init_word(input int a);
    if (a == 16) return 64'h0000_0000_DEAD_BEEF;
    return {32'hC0DE_0000 + 32'(a), 32'h1234_0000 + 32'(a * 7)};
  endfunction

  // Environment memory: one-cycle read latency, writes land at the clock edge.
  logic [DW-1:0] envmem [64];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) envmem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_wr_en) envmem[mem_addr[5:0]] <= mem_wdata;
      else           mem_rdata <= envmem[mem_addr[5:0]];
    end
  end

  int total = 0;
  int fails = 0;

  // Reference model state: owner 0=none 1=C 2=N, streak = consecutive grants.
  int            m_owner, m_streak, m_last;
  logic          exp_c_rv, exp_n_rv;
  logic [63:0]   exp_c_rd, exp_n_rd;
  logic [63:0]   refmem [64];
  logic          obs_c, obs_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (reset !== 1'b1) return 0;
    if (m_owner == 1 && c_req && (m_streak < B || !n_req)) return 1;
    if (m_owner == 2 && n_req && (m_streak < B || !c_req)) return 2;
    if (c_req && n_req) return (m_last == 1) ? 2 : 1;
    if (c_req) return 1;
    if (n_req) return 2;
    return 0;
  endfunction

  task automatic cycle();
    int          w;
    logic [63:0] ea, ed;
    logic        ew;
    @(negedge clk);
    w  = pick();
    ew = (w == 1) ? c_wr : (w == 2) ? n_wr : 1'b0;
    ea = (w == 1) ? 64'(c_addr) : (w == 2) ? 64'(n_addr) : 64'd0;
    ed = (w == 1) ? c_wdata : (w == 2) ? n_wdata : 64'd0;
    obs_c = c_gnt;
    obs_n = n_gnt;
    check("c_gnt",     64'(c_gnt),     64'(w == 1));
    check("n_gnt",     64'(n_gnt),     64'(w == 2));
    check("mem_en",    64'(mem_en),    64'(w != 0));
    check("mem_wr_en", 64'(mem_wr_en), 64'(ew));
    check("mem_addr",  64'(mem_addr),  ea);
    check("mem_wdata", mem_wdata,      ed);
    check("c_rvalid",  64'(c_rvalid),  64'(exp_c_rv));
    check("n_rvalid",  64'(n_rvalid),  64'(exp_n_rv));
    if (exp_c_rv) check("c_rdata", c_rdata, exp_c_rd);
    if (exp_n_rv) check("n_rdata", n_rdata, exp_n_rd);
`ifdef DMEM_ARB_STATS_EN
    check("c_wait_cnt", 64'(c_wait_cnt), 64'(m_cwait));
    check("n_wait_cnt", 64'(n_wait_cnt), 64'(m_nwait));
    if (reset !== 1'b1 || stats_clr) begin
      m_cwait = 0;
      m_nwait = 0;
    end else begin
      if (c_req && w != 1 && m_cwait != 32'hFFFF_FFFF) m_cwait++;
      if (n_req && w != 2 && m_nwait != 32'hFFFF_FFFF) m_nwait++;
    end
`endif
    exp_c_rv = (w == 1) && !c_wr;
    exp_n_rv = (w == 2) && !n_wr;
    if (exp_c_rv) exp_c_rd = refmem[c_addr[5:0]];
    if (exp_n_rv) exp_n_rd = refmem[n_addr[5:0]];
    if (w == 1 && c_wr) refmem[c_addr[5:0]] = c_wdata;
    if (w == 2 && n_wr) refmem[n_addr[5:0]] = n_wdata;
    if (w != 0) begin
      m_streak = (w == m_owner) ? ((m_streak + 1 > B) ? B : m_streak + 1) : 1;
      m_owner  = w;
      m_last   = w;
    end else begin
      m_owner  = 0;
      m_streak = 0;
    end
    if (reset !== 1'b1) m_last = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic r, input logic w, input logic [31:0] a, input logic [63:0] d);
    c_req = r; c_wr = w; c_addr = a; c_wdata = d;
  endtask

  task automatic set_n(input logic r, input logic w, input logic [31:0] a, input logic [63:0] d);
    n_req = r; n_wr = w; n_addr = a; n_wdata = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] seq;
    int          first_n, cgrants;
    for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
    m_owner = 0; m_streak = 0; m_last = 1;
    exp_c_rv = 1'b0; exp_n_rv = 1'b0; exp_c_rd = '0; exp_n_rd = '0;
    obs_c = 1'b0; obs_n = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0; m_cwait = '0; m_nwait = '0;
`endif
    reset = 1'b0;
    set_c(1'b1, 1'b0, 32'h4, 64'h1);
    set_n(1'b1, 1'b1, 32'h5, 64'h2);
    @(posedge clk); #1;

    // Requests held high during reset are ignored.
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    set_n(1'b0, 1'b0, 32'h0, 64'h0);

    // C reads 0x10 alone.
    set_c(1'b1, 1'b0, 32'h10, 64'h0);
    cycle();
    check("tp1_c_gnt",    64'(obs_c),    64'd1);
    check("tp1_c_rvalid", 64'(c_rvalid), 64'd1);
    check("tp1_c_rdata",  c_rdata,       64'h0000_0000_DEAD_BEEF);
    check("tp1_n_rvalid", 64'(n_rvalid), 64'd0);
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();

    // Continuous contention: N,N,N,N,C,C,C,C,N,N,N,N.
    set_c(1'b1, 1'b0, 32'h3, 64'h0);
    set_n(1'b1, 1'b0, 32'h7, 64'h0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      seq[i] = obs_n;
      if (obs_c && obs_n) check("tp2_overlap", 64'd1, 64'd0);
    end
    check("tp2_order", 64'(seq), 64'(12'b1111_0000_1111));
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();

    // C bursts writes, N joins after two; C holds until its budget is spent.
    first_n = -1;
    for (int i = 0; i < 6; i++) begin
      set_c(1'b1, 1'b1, 32'(20 + i), {32'hA000_0000, 32'(i)});
      if (i >= 2) set_n(1'b1, 1'b0, 32'd20, 64'h0);
      cycle();
      if (obs_n && first_n < 0) first_n = i;
    end
    check("tp3_first_n", 64'(first_n), 64'd4);
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();

    // N read granted, then reset drops the pending strobe and last winner.
    set_n(1'b1, 1'b0, 32'd21, 64'h0);
    cycle();
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    reset = 1'b0;
    cycle();
    check("tp4_n_rvalid", 64'(n_rvalid), 64'd0);
    reset = 1'b1;
    set_c(1'b1, 1'b0, 32'd8, 64'h0);
    set_n(1'b1, 1'b0, 32'd9, 64'h0);
    cycle();
    check("tp4_n_first", 64'(obs_n), 64'd1);
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();

    // C alone is never forced to yield.
    cgrants = 0;
    set_c(1'b1, 1'b0, 32'd30, 64'h0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_c) cgrants++;
    end
    check("tp5_c_grants", 64'(cgrants), 64'd10);
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();

`ifdef DMEM_ARB_STATS_EN
    // Make N the last winner so C takes the next tie, then count N's waits.
    set_n(1'b1, 1'b0, 32'd1, 64'h0);
    cycle();
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    set_c(1'b1, 1'b0, 32'd2, 64'h0);
    set_n(1'b1, 1'b0, 32'd3, 64'h0);
    for (int i = 0; i < 4; i++) cycle();
    check("tp6_n_wait4", 64'(n_wait_cnt), 64'd4);
    for (int i = 0; i < 4; i++) cycle();
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    check("tp6_n_wait_clr", 64'(n_wait_cnt), 64'd0);
    set_c(1'b0, 1'b0, 32'h0, 64'h0);
    set_n(1'b0, 1'b0, 32'h0, 64'h0);
    cycle();
`endif

    // Randomized traffic: requests held until granted, occasional withdrawal and reset.
    for (int i = 0; i < 600; i++) begin
      if (obs_c || !c_req) begin
        set_c($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), {$urandom, $urandom});
      end else if ($urandom_range(0, 15) == 0) begin
        c_req = 1'b0;
      end
      if (obs_n || !n_req) begin
        set_n($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), {$urandom, $urandom});
      end else if ($urandom_range(0, 15) == 0) begin
        n_req = 1'b0;
      end
      reset = ($urandom_range(0, 99) != 0);
`ifdef DMEM_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
